// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Single-issue instruction fetch unit. Reads one 16-bit word
//               from program memory, presents it to decode with a
//               valid/ready handshake, then fetches the next word. Supports
//               branch/jump redirects from any state.
//
//               State sequence per word: FETCH -> WAIT -> HOLD -> FETCH.
//               FETCH issues the read, WAIT captures the returning word,
//               HOLD presents it until decode accepts it. At best this gives
//               one word every 3 cycles.
//
//               Optional feature (macro INSTRUCTION_FETCH_HALT_DETECT_EN):
//               a transferred word with opcode [15:12] = 4'hF parks the
//               unit in HALT (halted=1, no reads) until a redirect or reset.
//               Without the macro the HALT state does not exist and halted
//               is tied low.
//
// Ports       : clk            - clock, rising edge
//               rst            - synchronous active-high reset
//               mem_addr       - program-memory address (always the PC)
//               mem_rd_en      - program-memory read strobe
//               mem_rdata      - read data, valid one cycle after mem_rd_en
//               instruction    - fetched word presented to decode
//               instr_valid    - instruction/pc_out hold a valid word
//               instr_ready    - decode accepts the presented word
//               pc_out         - address the presented word came from
//               redirect_valid - load redirect_pc and restart fetching
//               redirect_pc    - redirect target address
//               halted         - fetch stopped on a HALT word
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_rd_en,
    input  logic [15:0]         mem_rdata,
    output logic [15:0]         instruction,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] c_pc_one = PC_WIDTH'(1);

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
`endif

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic [15:0]         r_instruction;
    logic                r_valid;

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    logic                r_halted;
    logic                w_halt_word;

    // The word being handed over is the registered one, so its opcode is
    // already stable in HOLD.
    assign w_halt_word = (r_instruction[15:12] == 4'hF);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_pc_out      <= '0;
            r_instruction <= 16'h0000;
            r_valid       <= 1'b0;
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
            r_halted      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Redirect beats everything else: any read in flight is dropped,
            // any presented word is withdrawn (or, if it was accepted this
            // same cycle, simply not re-presented), and HALT is released.
            r_state  <= ST_FETCH;
            r_pc     <= redirect_pc;
            r_valid  <= 1'b0;
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_instruction <= mem_rdata;
                    r_pc_out      <= r_pc;
                    r_valid       <= 1'b1;
                    r_pc          <= r_pc + c_pc_one;
                    r_state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
                        if (w_halt_word) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= ST_FETCH;
                        end
`else
                        r_state <= ST_FETCH;
`endif
                    end
                end
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
`endif
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Reset gates the strobe directly so no read is issued while rst is
    // held, yet the first cycle after release already reads RESET_PC.
    assign mem_rd_en   = (r_state == ST_FETCH) && !rst;
    assign mem_addr    = r_pc;
    assign instruction = r_instruction;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A behavioural
//               model tracks the next fetch address, whether a read is in
//               flight, the presented word and the halt flag, and every
//               DUT output is compared against it each cycle. Directed
//               scenarios cover in-order fetch, back-pressure, PC wrap,
//               redirects in WAIT and on a transfer, and the HALT opcode;
//               a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int         PC_WIDTH = 8;
    localparam logic [7:0] RESET_PC = 8'h10;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc_out;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;

    instruction_fetch #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rdata      (mem_rdata),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory image and read-response bookkeeping
    logic [15:0] mem [256];
    logic        last_rd;
    logic [7:0]  last_addr;

    // Reference model
    bit          m_init;
    logic [7:0]  m_pc;
    bit          m_inflight;
    bit          m_valid;
    logic [15:0] m_word;
    logic [7:0]  m_word_pc;
    bit          m_halted;

    // Observation logs
    logic [7:0]  issued [$];
    logic [23:0] taken  [$];
    bit          s_valid;
    bit          s_rd;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, advance the model.
    task automatic cycle(input bit r, input bit rdy, input bit rv, input logic [7:0] rpc);
        @(negedge clk);
        // Memory answers one cycle after the strobe; otherwise garbage.
        mem_rdata      = last_rd ? mem[last_addr] : 16'hDEAD;
        rst            = r;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("rd_en", mem_rd_en, !r && m_init && !m_valid && !m_inflight && !m_halted);
        if (m_init) begin
            check("addr",   mem_addr,    m_pc);
            check("valid",  instr_valid, m_valid);
            check("instr",  instruction, m_word);
            check("pc_out", pc_out,      m_word_pc);
            check("halted", halted,      m_halted);
        end
        s_valid   = instr_valid;
        s_rd      = mem_rd_en;
        last_rd   = mem_rd_en;
        last_addr = mem_addr;
        if (mem_rd_en) issued.push_back(mem_addr);
        if (instr_valid && rdy && !r) taken.push_back({pc_out, instruction});

        if (r) begin
            m_init     = 1'b1;
            m_pc       = RESET_PC;
            m_inflight = 1'b0;
            m_valid    = 1'b0;
            m_halted   = 1'b0;
            m_word     = 16'h0000;
            m_word_pc  = 8'h00;
        end else if (rv) begin
            m_pc       = rpc;
            m_inflight = 1'b0;
            m_valid    = 1'b0;
            m_halted   = 1'b0;
        end else if (m_inflight) begin
            m_word     = mem[m_pc];
            m_word_pc  = m_pc;
            m_valid    = 1'b1;
            m_pc       = m_pc + 8'd1;
            m_inflight = 1'b0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
                if (m_word[15:12] == 4'hF) m_halted = 1'b1;
`endif
            end
        end else if (!m_halted) begin
            m_inflight = 1'b1;
        end
    endtask

    task automatic clear_logs();
        issued.delete();
        taken.delete();
    endtask

    // Hold instr_ready low until a word is presented, within a cycle budget.
    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            seen = s_valid;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        mem_rdata      = 16'hDEAD;
        last_rd        = 1'b0;
        last_addr      = 8'h00;
        m_init         = 1'b0;
        m_pc           = 8'h00;
        m_inflight     = 1'b0;
        m_valid        = 1'b0;
        m_word         = 16'h0000;
        m_word_pc      = 8'h00;
        m_halted       = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
        mem[3] = 16'hF000;

        // Reset, with redirect and ready asserted to show reset wins
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h55);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("reset_addr", mem_addr, RESET_PC);
        check("reset_instr", instruction, 16'h0000);

        // In-order fetch from RESET_PC with decode always ready
        clear_logs();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("seq_count", 32'(issued.size() >= 3), 32'd1);
        check("seq_addr0", issued[0], 8'h10);
        check("seq_addr1", issued[1], 8'h11);
        check("seq_addr2", issued[2], 8'h12);
        check("seq_word0", taken[0], {8'h10, 16'h1010});
        check("seq_word1", taken[1], {8'h11, 16'h1011});
        check("seq_word2", taken[2], {8'h12, 16'h1012});

        // Back-pressure: hold five cycles, then accept, then refetch next cycle
        wait_valid("stall");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("stall_next_fetch", s_rd, 1'b1);

        // PC wrap from FF to 00
        cycle(1'b0, 1'b1, 1'b1, 8'hFF);
        clear_logs();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap_addr0", issued[0], 8'hFF);
        check("wrap_addr1", issued[1], 8'h00);
        check("wrap_word", taken[0], {8'hFF, 16'h10FF});

        // Redirect during WAIT discards the returning word
        for (int i = 0; i < 10 && !s_rd; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        clear_logs();
        cycle(1'b0, 1'b1, 1'b1, 8'h40);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("wait_redir_addr", issued[0], 8'h40);
        check("wait_redir_word", taken[0], {8'h40, 16'h1040});

        // Redirect on the transfer cycle of the word from 05
        cycle(1'b0, 1'b0, 1'b1, 8'h05);
        wait_valid("xfer");
        check("xfer_pc", pc_out, 8'h05);
        cycle(1'b0, 1'b1, 1'b1, 8'h20);
        clear_logs();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("xfer_redir_addr", issued[0], 8'h20);
        check("xfer_redir_word", taken[0], {8'h20, 16'h1020});

        // HALT opcode at address 3
        cycle(1'b0, 1'b1, 1'b1, 8'h03);
        clear_logs();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("halt_word", taken[0], {8'h03, 16'hF000});
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
        check("halt_flag", halted, 1'b1);
        check("halt_no_fetch", issued.size(), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        clear_logs();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("halt_resume", issued[0], 8'h00);
`else
        check("halt_flag", halted, 1'b0);
        check("halt_continue", issued[1], 8'h04);
`endif

        // Randomized phase: random memory, back-pressure, redirects, resets
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
